// File: rtl/sram_req_responder.sv
// ---------------------------------------------------------------------------
// sram_req_responder
//
// Turns single-cycle read/write request pulses into SRAM device cycles.
// Each side holds one pending request; an issue stage drives at most one
// SRAM operation per cycle from registered outputs. Writes win over reads
// when both are pending. A write never issues in the cycle right after a read
// issue (bus turnaround). Read data is returned READ_LATENCY cycles after the
// read ack, tracked by a valid shift register.
//
// Optional build macro:
//   SRAM_RESP_STATS_EN  - compile in the 32-bit rd_count / wr_count counters.
//                         When undefined, both ports are tied to zero.
//
// Ports:
//   clk, reset            clock (posedge), async active-high reset
//   rd_req, rd_addr       read request pulse and its address
//   rd_ack                read issued to the SRAM (1 cycle)
//   rd_data, rd_vld       returned read data, qualified by a 1-cycle pulse
//   wr_req, wr_addr,
//   wr_data               write request pulse with address and data
//   wr_ack                write issued to the SRAM (1 cycle)
//   enable                high when a new read can be accepted
//   sram_addr,
//   sram_wr_data, sram_we device-side address, write data, write strobe
//   sram_rd_data          device read data
//   rd_count, wr_count    completed reads / writes (stats build only)
//
// READ_LATENCY legal range is 1..8.
// ---------------------------------------------------------------------------
module sram_req_responder #(
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 72,
    parameter int READ_LATENCY    = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rd_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
    output logic                       rd_ack,
    output logic [SRAM_DATA_WIDTH-1:0] rd_data,
    output logic                       rd_vld,
    input  logic                       wr_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
    input  logic [SRAM_DATA_WIDTH-1:0] wr_data,
    output logic                       wr_ack,
    output logic                       enable,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
    output logic                       sram_we,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
    output logic [31:0]                rd_count,
    output logic [31:0]                wr_count
);

    typedef struct packed {
        logic [SRAM_ADDR_WIDTH-1:0] addr;
    } rd_ent_t;

    typedef struct packed {
        logic [SRAM_ADDR_WIDTH-1:0] addr;
        logic [SRAM_DATA_WIDTH-1:0] data;
    } wr_ent_t;

    logic    rd_pending;
    logic    wr_pending;
    logic    turn_q;       // a read issued last cycle; blocks a write this cycle
    rd_ent_t rd_q;
    wr_ent_t wr_q;

    logic    rd_accept;
    logic    wr_accept;
    logic    issue_rd;
    logic    issue_wr;

    // vld_pipe[0] is loaded from rd_ack, so the last stage lines up with the
    // device returning data READ_LATENCY cycles after the issue cycle.
    logic [READ_LATENCY-1:0] vld_pipe;

    // A request seen while one is pending, or while its ack is on the bus,
    // is a duplicate of the one already in flight.
    always_comb begin
        rd_accept = rd_req && !rd_pending && !rd_ack;
        wr_accept = wr_req && !wr_pending && !wr_ack;
        issue_wr  = wr_pending && !turn_q;
        // Reads yield to any pending write, even one held by turnaround,
        // so the write goes out on the very next cycle.
        issue_rd  = rd_pending && !wr_pending;
    end

    assign enable = !reset && !rd_pending;

    // Request capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pending <= 1'b0;
            wr_pending <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
        end else begin
            if (issue_rd) begin
                rd_pending <= 1'b0;
            end else if (rd_accept) begin
                rd_pending <= 1'b1;
                rd_q.addr  <= rd_addr;
            end
            if (issue_wr) begin
                wr_pending <= 1'b0;
            end else if (wr_accept) begin
                wr_pending <= 1'b1;
                wr_q.addr  <= wr_addr;
                wr_q.data  <= wr_data;
            end
        end
    end

    // Issue stage; address/data hold their last values on idle cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ack       <= 1'b0;
            wr_ack       <= 1'b0;
            sram_we      <= 1'b0;
            sram_addr    <= '0;
            sram_wr_data <= '0;
            turn_q       <= 1'b0;
        end else begin
            rd_ack  <= issue_rd;
            wr_ack  <= issue_wr;
            sram_we <= issue_wr;
            turn_q  <= issue_rd;
            if (issue_wr) begin
                sram_addr    <= wr_q.addr;
                sram_wr_data <= wr_q.data;
            end else if (issue_rd) begin
                sram_addr    <= rd_q.addr;
            end
        end
    end

    // Read valid shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_ack;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign rd_vld  = vld_pipe[READ_LATENCY-1];
    // Device data is only meaningful in the return cycle; zero elsewhere
    // keeps rd_data at 0 through reset.
    assign rd_data = rd_vld ? sram_rd_data : '0;

`ifdef SRAM_RESP_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    // Free-running wrap at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_vld) rd_cnt_q <= rd_cnt_q + 32'd1;
            if (wr_ack) wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_sram_req_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_req_responder
//
// Directed bench for sram_req_responder. A small SRAM model returns
// data_fn(address) READ_LATENCY cycles after the address is presented.
// Expected read data is queued when a read is driven and popped by a monitor
// on each rd_vld; directed steps check ack timing, arbitration, turnaround,
// duplicate suppression, reset and the statistics counters.
// ---------------------------------------------------------------------------
module tb_sram_req_responder;
    localparam int AW  = 19;
    localparam int DW  = 72;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          rd_vld;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          enable;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wr_data;
    logic          sram_we;
    logic [DW-1:0] sram_rd_data;
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    sram_req_responder #(
        .SRAM_ADDR_WIDTH(AW),
        .SRAM_DATA_WIDTH(DW),
        .READ_LATENCY   (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .rd_vld      (rd_vld),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .enable      (enable),
        .sram_addr   (sram_addr),
        .sram_wr_data(sram_wr_data),
        .sram_we     (sram_we),
        .sram_rd_data(sram_rd_data),
        .rd_count    (rd_count),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] data_fn(input logic [AW-1:0] a);
        return {9{a[7:0] ^ 8'hBB}};
    endfunction

    // SRAM model: address presented in cycle n -> data in cycle n+LAT
    logic [AW-1:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= sram_addr;
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign sram_rd_data = data_fn(apipe[LAT-1]);

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_ack"},       DW'(rd_ack),       '0);
        chk({tag, "_wr_ack"},       DW'(wr_ack),       '0);
        chk({tag, "_rd_vld"},       DW'(rd_vld),       '0);
        chk({tag, "_rd_data"},      rd_data,           '0);
        chk({tag, "_sram_addr"},    DW'(sram_addr),    '0);
        chk({tag, "_sram_wr_data"}, sram_wr_data,      '0);
        chk({tag, "_sram_we"},      DW'(sram_we),      '0);
        chk({tag, "_rd_count"},     DW'(rd_count),     '0);
        chk({tag, "_wr_count"},     DW'(wr_count),     '0);
        chk({tag, "_enable"},       DW'(enable),       '0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            chk("ack_exclusive", DW'(rd_ack & wr_ack), '0);
            if (rd_vld) begin
                if (exp_q.size() == 0) chk("rd_vld_unexpected", DW'(rd_vld), '0);
                else                   chk("rd_data_sb", rd_data, exp_q.pop_front());
            end
        end
    end

    localparam logic [DW-1:0] D1 = 72'h01_2345_6789_ABCD_EF01;
    localparam logic [DW-1:0] D2 = 72'hFE_DCBA_9876_5432_10FE;
    localparam logic [DW-1:0] D3 = 72'h5A_5A5A_A5A5_A5A5_5A5A;

    initial begin
        logic [DW-1:0] ab_word;
        logic [31:0]   exp_rc;
        ab_word = {9{8'hAB}};

        reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        cyc(2);
        chk_reset_outputs("reset");

        // Release with a read request; sampled at the first posedge
        reset = 1'b0; rd_req = 1'b1; rd_addr = 19'h00010;
        exp_q.push_back(data_fn(19'h00010));
        #1 chk("enable_after_release", DW'(enable), DW'(1));
        cyc(); rd_req = 1'b0;                                   // c0
        chk("s1_c0_rd_ack", DW'(rd_ack), '0);
        chk("s1_c0_enable", DW'(enable), '0);
        cyc();                                                   // c1
        chk("s1_c1_rd_ack", DW'(rd_ack), DW'(1));
        chk("s1_c1_sram_addr", DW'(sram_addr), DW'(19'h00010));
        chk("s1_c1_sram_we", DW'(sram_we), '0);
        cyc();                                                   // c2
        chk("s1_c2_rd_ack", DW'(rd_ack), '0);
        chk("s1_c2_enable", DW'(enable), DW'(1));
        cyc(); chk("s1_c3_rd_vld", DW'(rd_vld), '0);             // c3
        cyc();                                                   // c4
        chk("s1_c4_rd_vld", DW'(rd_vld), DW'(1));
        chk("s1_c4_rd_data", rd_data, ab_word);
        cyc(); chk("s1_c5_rd_vld", DW'(rd_vld), '0);             // c5

        // Read and write together: write first, then read with no gap
        rd_req = 1'b1; rd_addr = 19'h00020;
        wr_req = 1'b1; wr_addr = 19'h00005; wr_data = D1;
        exp_q.push_back(data_fn(19'h00020));
        cyc(); rd_req = 1'b0; wr_req = 1'b0;                    // c0
        cyc();                                                   // c1
        chk("s2_c1_wr_ack", DW'(wr_ack), DW'(1));
        chk("s2_c1_sram_we", DW'(sram_we), DW'(1));
        chk("s2_c1_sram_addr", DW'(sram_addr), DW'(19'h00005));
        chk("s2_c1_sram_wr_data", sram_wr_data, D1);
        chk("s2_c1_rd_ack", DW'(rd_ack), '0);
        cyc();                                                   // c2
        chk("s2_c2_rd_ack", DW'(rd_ack), DW'(1));
        chk("s2_c2_wr_ack", DW'(wr_ack), '0);
        chk("s2_c2_sram_we", DW'(sram_we), '0);
        chk("s2_c2_sram_addr", DW'(sram_addr), DW'(19'h00020));
        chk("s2_c2_wr_data_hold", sram_wr_data, D1);
        cyc(2); chk("s2_c4_rd_vld", DW'(rd_vld), '0);            // c4
        cyc();  chk("s2_c5_rd_vld", DW'(rd_vld), DW'(1));        // c5

        // Read then write one cycle later: turnaround idle cycle
        rd_req = 1'b1; rd_addr = 19'h00030;
        exp_q.push_back(data_fn(19'h00030));
        cyc();                                                   // c0
        rd_req = 1'b0; wr_req = 1'b1; wr_addr = 19'h7FFFF; wr_data = D2;
        cyc(); wr_req = 1'b0;                                    // c1
        chk("s3_c1_rd_ack", DW'(rd_ack), DW'(1));
        chk("s3_c1_sram_addr", DW'(sram_addr), DW'(19'h00030));
        cyc();                                                   // c2
        chk("s3_c2_sram_we", DW'(sram_we), '0);
        chk("s3_c2_wr_ack", DW'(wr_ack), '0);
        chk("s3_c2_rd_ack", DW'(rd_ack), '0);
        chk("s3_c2_addr_hold", DW'(sram_addr), DW'(19'h00030));
        cyc();                                                   // c3
        chk("s3_c3_wr_ack", DW'(wr_ack), DW'(1));
        chk("s3_c3_sram_we", DW'(sram_we), DW'(1));
        chk("s3_c3_sram_addr", DW'(sram_addr), DW'(19'h7FFFF));
        chk("s3_c3_sram_wr_data", sram_wr_data, D2);
        cyc();                                                   // c4
        chk("s3_c4_rd_vld", DW'(rd_vld), DW'(1));
        chk("s3_c4_wr_ack", DW'(wr_ack), '0);

        // Duplicate reads: re-pulse while pending, and while rd_ack is high
        rd_req = 1'b1; rd_addr = 19'h00040;
        wr_req = 1'b1; wr_addr = 19'h00041; wr_data = D3;
        exp_q.push_back(data_fn(19'h00040));
        cyc(); wr_req = 1'b0;                                    // c0
        chk("s4_c0_enable", DW'(enable), '0);
        cyc(); rd_req = 1'b0;                                    // c1
        chk("s4_c1_wr_ack", DW'(wr_ack), DW'(1));
        chk("s4_c1_rd_ack", DW'(rd_ack), '0);
        chk("s4_c1_enable", DW'(enable), '0);
        cyc();                                                   // c2
        chk("s4_c2_rd_ack", DW'(rd_ack), DW'(1));
        chk("s4_c2_enable", DW'(enable), DW'(1));
        chk("s4_c2_sram_addr", DW'(sram_addr), DW'(19'h00040));
        rd_req = 1'b1; rd_addr = 19'h00044;
        cyc(); rd_req = 1'b0;                                    // c3
        chk("s4_c3_rd_ack", DW'(rd_ack), '0);
        chk("s4_c3_enable", DW'(enable), DW'(1));
        cyc(); chk("s4_c4_rd_ack", DW'(rd_ack), '0);             // c4
        cyc(); chk("s4_c5_rd_vld", DW'(rd_vld), DW'(1));         // c5
        cyc(); chk("s4_c6_rd_vld", DW'(rd_vld), '0);             // c6
        cyc(); chk("s4_c7_rd_vld", DW'(rd_vld), '0);             // c7

        // Three reads in flight, reset while the third is acked
        rd_req = 1'b1; rd_addr = 19'h7FFFF;
        exp_q.push_back(data_fn(19'h7FFFF));
        cyc(); rd_req = 1'b0;                                    // c0
        cyc(); chk("s5_c1_rd_ack", DW'(rd_ack), DW'(1));         // c1
        cyc();                                                   // c2
        rd_req = 1'b1; rd_addr = 19'h00051;
        exp_q.push_back(data_fn(19'h00051));
        cyc(); rd_req = 1'b0;                                    // c3
        cyc();                                                   // c4
        chk("s5_c4_rd_ack", DW'(rd_ack), DW'(1));
        chk("s5_c4_rd_vld", DW'(rd_vld), DW'(1));
        cyc();                                                   // c5
        rd_req = 1'b1; rd_addr = 19'h00052;
        exp_q.push_back(data_fn(19'h00052));
        cyc(); rd_req = 1'b0;                                    // c6
        cyc();                                                   // c7
        chk("s5_c7_rd_ack", DW'(rd_ack), DW'(1));
        chk("s5_c7_rd_vld", DW'(rd_vld), DW'(1));
        #2 reset = 1'b1;
        exp_q.delete();  // the third read must never return
        #1 chk_reset_outputs("async_reset");
        cyc(2);
        reset = 1'b0;
        #1 chk("enable_after_release2", DW'(enable), DW'(1));
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("no_vld_after_reset", DW'(rd_vld), '0);
        end

        // Statistics counters
`ifdef SRAM_RESP_STATS_EN
        force dut.rd_cnt_q = 32'hFFFF_FFFF;
        cyc();
        release dut.rd_cnt_q;
        exp_rc = 32'hFFFF_FFFF;
`else
        exp_rc = 32'h0;
`endif
        chk("rd_count_preload", DW'(rd_count), DW'(exp_rc));
        rd_req = 1'b1; rd_addr = 19'h00060;
        exp_q.push_back(data_fn(19'h00060));
        cyc(); rd_req = 1'b0;                                    // c0
        cyc(4);                                                  // c4
        chk("s6_c4_rd_vld", DW'(rd_vld), DW'(1));
        cyc();                                                   // c5
        chk("rd_count_wrap", DW'(rd_count), '0);
        chk("wr_count_idle", DW'(wr_count), '0);

        cyc(2);
        chk("scoreboard_drained", DW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
